// File: rtl/bird_pkg.sv
// Shared definitions for the bird datapath and its controller.
package bird_pkg;

  localparam int unsigned SCREEN_W  = 160;
  localparam int unsigned SCREEN_H  = 120;
  localparam int unsigned SPRITE_W  = 8;
  localparam int unsigned SPRITE_H  = 8;
  localparam int unsigned STEP      = 2;
  localparam int unsigned FALL_STEP = 4;
  localparam int unsigned START_X   = 76;
  localparam int unsigned START_Y   = 100;

  localparam int unsigned X_W     = 8;
  localparam int unsigned Y_W     = 7;
  localparam int unsigned COL_W   = 3;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned NPIX    = SPRITE_W * SPRITE_H;

  localparam logic [X_W-1:0]   X_LIM     = X_W'(SCREEN_W - SPRITE_W);
  localparam logic [Y_W-1:0]   Y_LIM     = Y_W'(SCREEN_H - SPRITE_H);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(NPIX);

  localparam logic [STATE_W-1:0] ST_HOLD       = 4'h0;
  localparam logic [STATE_W-1:0] ST_CLEAR      = 4'h1;
  localparam logic [STATE_W-1:0] ST_UP_LEFT    = 4'h2;
  localparam logic [STATE_W-1:0] ST_UP_RIGHT   = 4'h3;
  localparam logic [STATE_W-1:0] ST_PREHOLD    = 4'h4;
  localparam logic [STATE_W-1:0] ST_DRAW       = 4'h5;
  localparam logic [STATE_W-1:0] ST_DOWN_RIGHT = 4'h6;
  localparam logic [STATE_W-1:0] ST_DOWN_LEFT  = 4'h7;
  localparam logic [STATE_W-1:0] ST_SHOT       = 4'h8;
  localparam logic [STATE_W-1:0] ST_ESCAPE     = 4'h9;
  localparam logic [STATE_W-1:0] ST_RESET      = 4'hA;

  localparam logic [COL_W-1:0] BG_COLOUR   = 3'b011;
  localparam logic [COL_W-1:0] BIRD_COLOUR = 3'b110;
  localparam logic [COL_W-1:0] SHOT_COLOUR = 3'b100;

  typedef enum logic [1:0] {
    MODE_NORMAL  = 2'd0,
    MODE_FALLING = 2'd1,
    MODE_FLEEING = 2'd2
  } mode_e;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
  } pixel_t;

  // One STEP along an axis, reflecting off [0, lim] instead of leaving it.
  function automatic logic [7:0] step_bounce(input logic [7:0] pos, input logic inc,
                                             input logic [7:0] lim);
    logic [7:0] r;
    if (inc) r = (pos > lim - 8'(STEP)) ? pos - 8'(STEP) : pos + 8'(STEP);
    else     r = (pos < 8'(STEP))       ? pos + 8'(STEP) : pos - 8'(STEP);
    return r;
  endfunction

endpackage

// File: rtl/bird_if.sv
// Controller <-> bird datapath bus, including the framebuffer write port.
interface bird_if;
  import bird_pkg::*;

  logic [STATE_W-1:0] state;
  logic               done_drawing;
  logic               flying;
  logic [X_W-1:0]     vga_x;
  logic [Y_W-1:0]     vga_y;
  logic [COL_W-1:0]   vga_colour;
  logic               vga_plot;
  logic [X_W-1:0]     bird_x;
  logic [Y_W-1:0]     bird_y;

  modport master (output state,
                  input  done_drawing, flying, vga_x, vga_y, vga_colour, vga_plot,
                         bird_x, bird_y);
  modport slave  (input  state,
                  output done_drawing, flying, vga_x, vga_y, vga_colour, vga_plot,
                         bird_x, bird_y);
endinterface

// File: rtl/bird_datapath_sprite_plotter.sv
// Walks an 8x8 sprite row-major, one registered pixel per clock.
module sprite_plotter
  import bird_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             run,
  input  logic [X_W-1:0]   base_x,
  input  logic [Y_W-1:0]   base_y,
  input  logic [COL_W-1:0] colour,
  output pixel_t           pix,
  output logic             plot,
  output logic             done,
  output logic [CNT_W-1:0] pix_cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  pixel_t           pix_q, pix_d;
  logic             plot_q, plot_d;
  logic             done_q, done_d;
  logic [5:0]       idx;

  // Pixel sequencing: start emits pixel 0, run continues, leaving aborts.
  always_comb begin
    cnt_d  = cnt_q;
    pix_d  = pix_q;
    plot_d = 1'b0;
    done_d = 1'b0;
    idx    = cnt_q[5:0];
    if (start) begin
      idx    = 6'd0;
      cnt_d  = CNT_W'(1);
      plot_d = 1'b1;
    end else if (run && cnt_q != '0 && cnt_q < PIX_LAST) begin
      cnt_d  = cnt_q + CNT_W'(1);
      plot_d = 1'b1;
    end else if (run && cnt_q == PIX_LAST) begin
      done_d = 1'b1;
    end else if (!run) begin
      cnt_d = '0;
    end
    if (plot_d) begin
      pix_d.x      = base_x + X_W'(idx[2:0]);
      pix_d.y      = base_y + Y_W'(idx[5:3]);
      pix_d.colour = colour;
    end
  end

  // Plotter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      pix_q  <= '0;
      plot_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pix_q  <= pix_d;
      plot_q <= plot_d;
      done_q <= done_d;
    end
  end

  assign pix     = pix_q;
  assign plot    = plot_q;
  assign done    = done_q;
  assign pix_cnt = cnt_q;

endmodule

// File: rtl/bird_datapath.sv
// Bird datapath: position/mode tracking and sprite redraw for the controller.
module bird_datapath
  import bird_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  bird_if.slave bus
);

  logic [STATE_W-1:0] prev_state_q;
  logic [STATE_W-1:0] st;
  logic               entry, run, start;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  mode_e              mode_q, mode_d;
  logic               gone_q, gone_d;
  logic [COL_W-1:0]   colour;
  pixel_t             pl_pix;
  logic               pl_plot, pl_done;
  logic [CNT_W-1:0]   pl_cnt;

  // State decode; unused codes behave as HOLD.
  always_comb begin
    st     = (bus.state > ST_RESET) ? ST_HOLD : bus.state;
    entry  = (bus.state != prev_state_q);
    run    = (st == ST_CLEAR) || (st == ST_DRAW);
    start  = entry && run;
    colour = (st == ST_CLEAR) ? BG_COLOUR :
             (mode_q == MODE_FALLING) ? SHOT_COLOUR : BIRD_COLOUR;
  end

  // Position and mode updates, applied once per state entry.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    gone_d = gone_q;
    if (st == ST_RESET) begin
      x_d    = X_W'(START_X);
      y_d    = Y_W'(START_Y);
      mode_d = MODE_NORMAL;
      gone_d = 1'b0;
    end else if (entry) begin
      case (st)
        ST_UP_LEFT, ST_UP_RIGHT, ST_DOWN_RIGHT, ST_DOWN_LEFT: begin
          if (mode_q == MODE_NORMAL) begin
            x_d = step_bounce(x_q, (st == ST_UP_RIGHT) || (st == ST_DOWN_RIGHT), X_LIM);
            y_d = Y_W'(step_bounce(8'(y_q), (st == ST_DOWN_RIGHT) || (st == ST_DOWN_LEFT),
                                   8'(Y_LIM)));
          end
        end
        ST_SHOT:   if (mode_q == MODE_NORMAL) mode_d = MODE_FALLING;
        ST_ESCAPE: if (mode_q == MODE_NORMAL) mode_d = MODE_FLEEING;
        ST_DRAW: begin
          // Reaching the screen edge ends the sequence.
          if (mode_q == MODE_FALLING) begin
            if (y_q >= Y_LIM - Y_W'(FALL_STEP)) begin
              y_d    = Y_LIM;
              gone_d = 1'b1;
            end else begin
              y_d = y_q + Y_W'(FALL_STEP);
            end
          end else if (mode_q == MODE_FLEEING) begin
            if (y_q <= Y_W'(FALL_STEP)) begin
              y_d    = '0;
              gone_d = 1'b1;
            end else begin
              y_d = y_q - Y_W'(FALL_STEP);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_state_q <= ST_PREHOLD;
      x_q          <= X_W'(START_X);
      y_q          <= Y_W'(START_Y);
      mode_q       <= MODE_NORMAL;
      gone_q       <= 1'b0;
    end else begin
      prev_state_q <= bus.state;
      x_q          <= x_d;
      y_q          <= y_d;
      mode_q       <= mode_d;
      gone_q       <= gone_d;
    end
  end

  // The first pixel is launched with the position being written this cycle.
  sprite_plotter u_plotter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .run     (run),
    .base_x  (x_d),
    .base_y  (y_d),
    .colour  (colour),
    .pix     (pl_pix),
    .plot    (pl_plot),
    .done    (pl_done),
    .pix_cnt (pl_cnt)
  );

  // A completed pass leaves the counter parked after the last pixel.
  assert property (@(posedge clk) disable iff (!reset_n) pl_done |-> (pl_cnt == PIX_LAST));

  assign bus.vga_x        = pl_pix.x;
  assign bus.vga_y        = pl_pix.y;
  assign bus.vga_colour   = pl_pix.colour;
  assign bus.vga_plot     = pl_plot;
  assign bus.done_drawing = pl_done;
  assign bus.bird_x       = x_q;
  assign bus.bird_y       = y_q;
  assign bus.flying       = ((mode_q != MODE_NORMAL) || (st == ST_SHOT) || (st == ST_ESCAPE))
                            && !gone_q;

endmodule

// File: tb/tb_bird_datapath.sv
// Bench for bird_datapath: behavioural position model feeds a pixel scoreboard.
module tb_bird_datapath;
  import bird_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  bird_if bif();

  bird_datapath u_dut (.clk(clk), .reset_n(reset_n), .bus(bif));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  pixel_t exp_q[$];

  int mx, my, mmode;
  bit mgone;
  logic [3:0] mprev;

  task automatic model_reset();
    mx = 76; my = 100; mmode = 0; mgone = 0; mprev = 4'h4;
    exp_q.delete();
  endtask

  // Drive a state code; on entry update the model and queue any expected pass.
  task automatic set_state(input logic [3:0] s);
    logic [3:0] e;
    int dx, dy, nx, ny;
    logic [2:0] col;
    pixel_t p;
    bif.state = s;
    if (s == mprev) return;
    mprev = s;
    exp_q.delete();
    e = (s > 4'hA) ? 4'h0 : s;
    dx = 0; dy = 0;
    case (e)
      4'h2: begin dx = -1; dy = -1; end
      4'h3: begin dx =  1; dy = -1; end
      4'h6: begin dx =  1; dy =  1; end
      4'h7: begin dx = -1; dy =  1; end
      4'h8: if (mmode == 0) mmode = 1;
      4'h9: if (mmode == 0) mmode = 2;
      4'hA: begin mx = 76; my = 100; mmode = 0; mgone = 0; end
      4'h5: begin
        if (mmode == 1) begin
          ny = my + 4;
          if (ny >= 112) begin ny = 112; mgone = 1; end
          my = ny;
        end else if (mmode == 2) begin
          ny = my - 4;
          if (ny <= 0) begin ny = 0; mgone = 1; end
          my = ny;
        end
      end
      default: ;
    endcase
    if (dx != 0 && mmode == 0) begin
      nx = mx + 2 * dx;
      if (nx < 0 || nx > 152) nx = mx - 2 * dx;
      ny = my + 2 * dy;
      if (ny < 0 || ny > 112) ny = my - 2 * dy;
      mx = nx; my = ny;
    end
    if (e == 4'h1 || e == 4'h5) begin
      col = (e == 4'h1) ? 3'b011 : ((mmode == 1) ? 3'b100 : 3'b110);
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          p.x = 8'(mx + c);
          p.y = 7'(my + r);
          p.colour = col;
          exp_q.push_back(p);
        end
    end
  endtask

  // One clock; plotted pixels are popped from the scoreboard and compared.
  task automatic tick();
    pixel_t p;
    @(negedge clk);
    if (bif.vga_plot === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d", bif.vga_x, bif.vga_y, bif.vga_colour);
      end else begin
        p = exp_q.pop_front();
        if ({bif.vga_x, bif.vga_y, bif.vga_colour} !== p) begin
          errors++;
          $display("FAIL pixel got x=%0d y=%0d c=%0d exp x=%0d y=%0d c=%0d",
                   bif.vga_x, bif.vga_y, bif.vga_colour, p.x, p.y, p.colour);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    model_reset();
    bif.state = 4'h0;
    ticks(2);
    checks++;
    if ({bif.done_drawing, bif.vga_plot, bif.flying, bif.vga_x, bif.vga_y, bif.vga_colour} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got done=%0b plot=%0b fly=%0b x=%0d y=%0d c=%0d exp all 0",
               bif.done_drawing, bif.vga_plot, bif.flying, bif.vga_x, bif.vga_y, bif.vga_colour);
    end
    checks++;
    if (bif.bird_x !== 8'd76 || bif.bird_y !== 7'd100) begin
      errors++;
      $display("FAIL reset_pos got (%0d,%0d) exp (76,100)", bif.bird_x, bif.bird_y);
    end
    set_state(4'h0);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_draw();
    set_state(4'h5);
    ticks(64);
    checks++;
    if (bif.done_drawing !== 1'b0) begin
      errors++; $display("FAIL draw_done_early got %0b exp 0", bif.done_drawing);
    end
    tick();
    checks++;
    if (bif.done_drawing !== 1'b1 || bif.vga_plot !== 1'b0) begin
      errors++; $display("FAIL draw_done got done=%0b plot=%0b exp 1 0", bif.done_drawing, bif.vga_plot);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL draw_count got %0d pixels missing exp 0", exp_q.size());
    end
    checks++;
    if (bif.flying !== 1'b0) begin
      errors++; $display("FAIL draw_flying got %0b exp 0", bif.flying);
    end
  endtask

  task automatic test_hold_clear();
    ticks(2);
    checks++;
    if (bif.done_drawing !== 1'b1) begin
      errors++; $display("FAIL done_hold got %0b exp 1", bif.done_drawing);
    end
    set_state(4'h0);
    tick();
    checks++;
    if (bif.done_drawing !== 1'b0 || bif.vga_plot !== 1'b0) begin
      errors++; $display("FAIL done_drop got done=%0b plot=%0b exp 0 0", bif.done_drawing, bif.vga_plot);
    end
    set_state(4'hC);
    ticks(3);
    checks++;
    if (bif.bird_x !== 8'd76 || bif.bird_y !== 7'd100 || bif.vga_plot !== 1'b0) begin
      errors++; $display("FAIL code_c_hold got (%0d,%0d) plot=%0b exp (76,100) 0", bif.bird_x, bif.bird_y, bif.vga_plot);
    end
    set_state(4'h1);
    ticks(65);
    checks++;
    if (bif.done_drawing !== 1'b1 || exp_q.size() != 0) begin
      errors++; $display("FAIL clear_pass got done=%0b left=%0d exp 1 0", bif.done_drawing, exp_q.size());
    end
    // Abort a DRAW mid-pass by going straight to CLEAR, which restarts.
    set_state(4'h5);
    ticks(10);
    set_state(4'h1);
    ticks(64);
    checks++;
    if (bif.done_drawing !== 1'b0) begin
      errors++; $display("FAIL restart_done_early got %0b exp 0", bif.done_drawing);
    end
    tick();
    checks++;
    if (bif.done_drawing !== 1'b1 || exp_q.size() != 0) begin
      errors++; $display("FAIL restart_pass got done=%0b left=%0d exp 1 0", bif.done_drawing, exp_q.size());
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 38; i++) begin
      set_state((i % 2 == 1) ? 4'h6 : 4'h3);
      tick();
    end
    set_state(4'h0);
    tick();
    checks++;
    if (bif.bird_x !== 8'd152 || bif.bird_y !== 7'd100) begin
      errors++; $display("FAIL walk_right got (%0d,%0d) exp (152,100)", bif.bird_x, bif.bird_y);
    end
    set_state(4'h3);
    tick();
    checks++;
    if (bif.bird_x !== 8'd150 || bif.bird_y !== 7'd98) begin
      errors++; $display("FAIL bounce_x got (%0d,%0d) exp (150,98)", bif.bird_x, bif.bird_y);
    end
  endtask

  task automatic test_shot();
    logic [6:0] exp_y [3] = '{7'd104, 7'd108, 7'd112};
    set_state(4'hA);
    tick();
    checks++;
    if (bif.bird_x !== 8'd76 || bif.bird_y !== 7'd100) begin
      errors++; $display("FAIL reset_state got (%0d,%0d) exp (76,100)", bif.bird_x, bif.bird_y);
    end
    set_state(4'h8);
    #1;
    checks++;
    if (bif.flying !== 1'b1) begin
      errors++; $display("FAIL shot_flying got %0b exp 1", bif.flying);
    end
    tick();
    set_state(4'h2);
    tick();
    checks++;
    if (bif.bird_x !== 8'd76 || bif.bird_y !== 7'd100) begin
      errors++; $display("FAIL move_while_falling got (%0d,%0d) exp (76,100)", bif.bird_x, bif.bird_y);
    end
    for (int k = 0; k < 3; k++) begin
      set_state(4'h1);
      ticks(65);
      set_state(4'h5);
      ticks(65);
      checks++;
      if (bif.bird_y !== exp_y[k] || bif.done_drawing !== 1'b1 || exp_q.size() != 0) begin
        errors++; $display("FAIL fall_%0d got y=%0d done=%0b exp y=%0d done=1", k, bif.bird_y, bif.done_drawing, exp_y[k]);
      end
      checks++;
      if (bif.flying !== (k < 2)) begin
        errors++; $display("FAIL fall_flying_%0d got %0b exp %0b", k, bif.flying, (k < 2));
      end
    end
    set_state(4'hA);
    tick();
    checks++;
    if (bif.bird_x !== 8'd76 || bif.bird_y !== 7'd100 || bif.flying !== 1'b0) begin
      errors++; $display("FAIL respawn got (%0d,%0d) fly=%0b exp (76,100) 0", bif.bird_x, bif.bird_y, bif.flying);
    end
  endtask

  task automatic test_escape();
    for (int i = 0; i < 47; i++) begin
      set_state((i % 2 == 0) ? 4'h2 : 4'h3);
      tick();
    end
    set_state(4'h0);
    tick();
    checks++;
    if (bif.bird_x !== 8'd74 || bif.bird_y !== 7'd6) begin
      errors++; $display("FAIL climb got (%0d,%0d) exp (74,6)", bif.bird_x, bif.bird_y);
    end
    set_state(4'h9);
    #1;
    checks++;
    if (bif.flying !== 1'b1) begin
      errors++; $display("FAIL escape_flying got %0b exp 1", bif.flying);
    end
    tick();
    set_state(4'h8);
    tick();
    set_state(4'h5);
    ticks(65);
    checks++;
    if (bif.bird_y !== 7'd2 || bif.flying !== 1'b1 || exp_q.size() != 0) begin
      errors++; $display("FAIL flee_1 got y=%0d fly=%0b exp y=2 fly=1", bif.bird_y, bif.flying);
    end
    set_state(4'h1);
    ticks(65);
    set_state(4'h5);
    ticks(65);
    checks++;
    if (bif.bird_y !== 7'd0 || bif.flying !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL flee_2 got y=%0d fly=%0b exp y=0 fly=0", bif.bird_y, bif.flying);
    end
  endtask

  task automatic test_async_reset();
    set_state(4'hA);
    tick();
    set_state(4'h5);
    ticks(30);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bif.vga_plot !== 1'b0 || bif.done_drawing !== 1'b0 || bif.vga_x !== 8'd0 || bif.bird_y !== 7'd100) begin
      errors++; $display("FAIL async_reset got plot=%0b done=%0b x=%0d by=%0d exp 0 0 0 100",
                         bif.vga_plot, bif.done_drawing, bif.vga_x, bif.bird_y);
    end
    model_reset();
    set_state(4'h0);
    ticks(2);
    reset_n = 1'b1;
    ticks(10);
    checks++;
    if (bif.vga_plot !== 1'b0 || bif.done_drawing !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got plot=%0b done=%0b exp 0 0", bif.vga_plot, bif.done_drawing);
    end
    set_state(4'h5);
    ticks(65);
    checks++;
    if (bif.done_drawing !== 1'b1 || exp_q.size() != 0) begin
      errors++; $display("FAIL post_reset_pass got done=%0b left=%0d exp 1 0", bif.done_drawing, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_draw();
    test_hold_clear();
    test_bounce();
    test_shot();
    test_escape();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bird_datapath.md
# bird_datapath

Datapath responder for the bird controller FSM: consumes its 4-bit state code and performs the work each state names. Its jobs are clearing and redrawing the 8×8 bird sprite, stepping the bird position, and running the fall/flee sequence after a shot or escape. It returns `done_drawing` and `flying` to the controller. It drives the VGA framebuffer write port (x, y, colour, plot) for the bird layer.

## Interface
- `SCREEN_W`, 160, framebuffer width in pixels
- `SCREEN_H`, 120, framebuffer height in pixels
- `SPRITE_W`, 8, sprite width; `SPRITE_H`, 8, sprite height
- `STEP`, 2, pixels per normal move
- `FALL_STEP`, 4, pixels per fall/flee tick
- `START_X`, 76, `START_Y`, 100, spawn position (sprite top-left)
- `BG_COLOUR`, 3'b011; `BIRD_COLOUR`, 3'b110; `SHOT_COLOUR`, 3'b100
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `state`  in  4  controller state code
- `done_drawing`  out  1  current CLEAR/DRAW pass complete (level)
- `flying`  out  1  bird in fall/flee sequence and still on screen
- `vga_x`  out  8  pixel x
- `vga_y`  out  7  pixel y
- `vga_colour`  out  3  pixel colour
- `vga_plot`  out  1  write strobe
- `bird_x`  out  8  current sprite x, for hit detection
- `bird_y`  out  7  current sprite y, for hit detection

## Operation
- State codes: HOLD 0, CLEAR 1, UP_LEFT 2, UP_RIGHT 3, PREHOLD 4, DRAW 5, DOWN_RIGHT 6, DOWN_LEFT 7, SHOT 8, ESCAPE 9, RESET A. Codes B–F are treated as HOLD.
- Internal `prev_state` register. Entry into a state means `state != prev_state`.
- Mode register: NORMAL, FALLING, FLEEING. Separate `gone` flag.
- Move states (2,3,6,7), each on entry:
  - x ±STEP, y ±STEP; UP means y decreases.
  - Edge bounce per axis: if the step would put the sprite outside [0, SCREEN_W−SPRITE_W] or [0, SCREEN_H−SPRITE_H], step the opposite direction on that axis instead.
  - Moves are ignored when mode ≠ NORMAL.
- SHOT on entry:
  - mode←FALLING, unless already FALLING or FLEEING.
  - SHOT received while FLEEING is ignored.
- ESCAPE on entry: mode←FLEEING, only if mode is NORMAL.
- DRAW on entry with mode ≠ NORMAL:
  - FALLING: y += FALL_STEP.
  - FLEEING: y −= FALL_STEP.
  - If the result would leave [0, SCREEN_H−SPRITE_H], clamp to the edge and set `gone`.
- RESET (and `reset_n` low): x←START_X, y←START_Y, mode←NORMAL, gone←0.
- `flying` = (mode ≠ NORMAL or state ∈ {SHOT, ESCAPE}) and !gone. This is combinational so the controller sees it in the same SHOT/ESCAPE cycle.
- CLEAR/DRAW pass:
  - Plots all SPRITE_W×SPRITE_H pixels, row-major, at (x+col, y+row).
  - CLEAR colour: BG_COLOUR.
  - DRAW colour: BIRD_COLOUR in NORMAL/FLEEING, SHOT_COLOUR in FALLING.
  - DRAW uses the position already updated on that entry.
- HOLD, PREHOLD, move, SHOT, ESCAPE, RESET: `vga_plot`=0.

## Timing
- Reset values: done_drawing 0, vga_plot 0, vga_x/vga_y/vga_colour 0, bird_x START_X, bird_y START_Y, flying 0, mode NORMAL, prev_state 4'h4.
- Entry cycle E (CLEAR/DRAW):
  - Pixel counter cleared.
  - Cycles E+1..E+64: registered plot outputs, one pixel per clock, `vga_plot`=1.
  - `done_drawing` rises at E+65 and holds until `state` changes; it drops the cycle after the change.
- Leaving CLEAR/DRAW mid-pass aborts the pass: plot drops the next cycle and the counter is cleared.
- Re-entering the same state after another state restarts the pass.
- Position updates take effect the cycle after entry; `bird_x`/`bird_y` are registered.
- Async reset mid-pass: all outputs take reset values immediately.

## Structure
- Package `bird_pkg`: state-code localparams (shared with the controller), mode encoding, colour constants.
- Sub-module `sprite_plotter`:
  - Inputs: start, base x/y, colour.
  - Outputs: pixel counter, plot strobe, done.
- Position, mode and bounce logic stay in the top module.

## Test plan
- Reset, then `state`=DRAW held: 64 plots with x 76..83, y 100..107, colour 3'b110; done_drawing high at E+65; flying 0.
- Sequence DRAW→HOLD→CLEAR: plot drops within 1 cycle; CLEAR plots 64 pixels of 3'b011 at the same coordinates; done_drawing re-rises.
- Bird at x=152, `state`=UP_RIGHT: x→150 (bounce), y→98.
- `state`=SHOT: flying=1 in that same cycle. Then repeated CLEAR→DRAW: y advances 100→104→108→112 (clamped, gone=1) with colour 3'b100; flying drops to 0. Then RESET: position returns to (76,100).
- ESCAPE from y=6: first DRAW sets y=2; second DRAW clamps y=0, gone=1; flying=0.
- Assert reset_n low at E+30 of a DRAW pass: vga_plot and done_drawing go to 0 asynchronously; no further plots after release until a new entry.
